// File: rtl/rh_temp_pkg.sv
// Shared definitions for the RH/temperature data-ready poller: FSM encoding,
// register bit position, counter widths and legal parameter ranges.
package rh_temp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_EVAL  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    localparam int DRDY_BIT         = 0;
    localparam int READ_LATENCY_MIN = 1;
    localparam int READ_LATENCY_MAX = 4;
    localparam int FILTER_LEN_MIN   = 1;
    localparam int FILTER_LEN_MAX   = 15;
    localparam int POLL_MARGIN      = 3;
    localparam int LAT_W            = 3;
    localparam int AGREE_W          = 4;
    localparam int COUNT_W          = 16;

    function automatic bit latency_legal(input int rl);
        return (rl >= READ_LATENCY_MIN) && (rl <= READ_LATENCY_MAX);
    endfunction

    function automatic bit filter_legal(input int fl);
        return (fl >= FILTER_LEN_MIN) && (fl <= FILTER_LEN_MAX);
    endfunction

    // The gap state needs at least one cycle between EVAL and the next ISSUE.
    function automatic bit interval_legal(input int pi, input int rl);
        return pi >= (rl + POLL_MARGIN);
    endfunction

endpackage

// File: rtl/rh_temp_level_filter.sv
// Debounces the sampled data-ready bit: the level flips only after FILTER_LEN
// consecutive disagreeing samples; rising flips emit a pulse and bump a count.
module rh_temp_level_filter
    import rh_temp_pkg::*;
#(
    parameter int FILTER_LEN = 3
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_sample_valid,
    input  logic               i_sample,
    output logic               o_drdy_level,
    output logic               o_ready_pulse,
    output logic [COUNT_W-1:0] o_ready_count
);

    localparam logic [AGREE_W-1:0] AGREE_LIMIT = AGREE_W'(FILTER_LEN);

    logic [AGREE_W-1:0] r_agree_cnt;
    logic               r_level;
    logic               r_pulse;
    logic [COUNT_W-1:0] r_ready_count;
    logic [AGREE_W-1:0] w_agree_inc;
    logic               w_flip;

    assign w_agree_inc = r_agree_cnt + 1'b1;
    assign w_flip      = (i_sample != r_level) && (w_agree_inc == AGREE_LIMIT);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_agree_cnt   <= '0;
            r_level       <= 1'b0;
            r_pulse       <= 1'b0;
            r_ready_count <= '0;
        end else begin
            r_pulse <= 1'b0;
            if (i_sample_valid) begin
                if (i_sample == r_level) begin
                    r_agree_cnt <= '0;
                end else if (w_flip) begin
                    r_agree_cnt <= '0;
                    r_level     <= i_sample;
                    // Only the not-ready -> ready edge is an event; the count wraps naturally.
                    if (i_sample) begin
                        r_pulse       <= 1'b1;
                        r_ready_count <= r_ready_count + 1'b1;
                    end
                end else begin
                    r_agree_cnt <= w_agree_inc;
                end
            end
        end
    end

    assign o_drdy_level  = r_level;
    assign o_ready_pulse = r_pulse;
    assign o_ready_count = r_ready_count;

endmodule

// File: rtl/rh_temp_drdy_poller.sv
// Avalon-MM read initiator that polls the sensor drdy_n PIO at a fixed interval
// and hands each accepted sample to the level filter.
module rh_temp_drdy_poller
    import rh_temp_pkg::*;
#(
    parameter int POLL_INTERVAL = 1000,
    parameter int READ_LATENCY  = 1,
    parameter int FILTER_LEN    = 3,
    parameter int DRDY_ADDR     = 0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    output logic [1:0]         avm_address,
    output logic               avm_read,
    input  logic [31:0]        avm_readdata,
    output logic               drdy_level,
    output logic               ready_pulse,
    output logic [COUNT_W-1:0] ready_count
);

    if (!latency_legal(READ_LATENCY)) begin : g_bad_latency
        $error("rh_temp_drdy_poller: READ_LATENCY out of range");
    end
    if (!filter_legal(FILTER_LEN)) begin : g_bad_filter
        $error("rh_temp_drdy_poller: FILTER_LEN out of range");
    end
    if (!interval_legal(POLL_INTERVAL, READ_LATENCY)) begin : g_bad_interval
        $error("rh_temp_drdy_poller: POLL_INTERVAL too short for READ_LATENCY");
    end

    localparam int                 IVL_W    = $clog2(POLL_INTERVAL + 1);
    localparam logic [IVL_W-1:0]   IVL_LAST = IVL_W'(POLL_INTERVAL - 1);
    localparam logic [LAT_W-1:0]   LAT_LOAD = LAT_W'(READ_LATENCY);
    localparam logic [1:0]         ADDR     = 2'(DRDY_ADDR);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [LAT_W-1:0]   r_lat_cnt;
    logic [IVL_W-1:0]   r_ivl_cnt;
    logic               r_abort;
    logic               r_sample;
    logic               r_avm_read;
    logic [1:0]         r_avm_address;
    logic               w_data_cycle;
    logic               w_abort_now;
    logic               w_read_nxt;
    logic               w_take_sample;
    logic               w_sample_valid;
    logic               w_unused_rdata;

    assign w_data_cycle   = (r_state == ST_WAIT) && (r_lat_cnt == LAT_W'(1));
    assign w_abort_now    = r_abort || !enable;
    assign w_unused_rdata = ^avm_readdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (enable) w_state_nxt = ST_ISSUE;
            ST_ISSUE: w_state_nxt = ST_WAIT;
            ST_WAIT:  if (w_data_cycle) w_state_nxt = w_abort_now ? ST_IDLE : ST_EVAL;
            ST_EVAL:  w_state_nxt = enable ? ST_GAP : ST_IDLE;
            ST_GAP: begin
                if (!enable)                    w_state_nxt = ST_IDLE;
                else if (r_ivl_cnt == IVL_LAST) w_state_nxt = ST_ISSUE;
            end
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Read strobe is registered, so it is derived from the state being entered.
    always_comb begin
        w_read_nxt     = (w_state_nxt == ST_ISSUE);
        w_take_sample  = w_data_cycle && !w_abort_now;
        w_sample_valid = (r_state == ST_EVAL);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_avm_read    <= 1'b0;
            r_avm_address <= ADDR;
            r_lat_cnt     <= '0;
            r_ivl_cnt     <= '0;
            r_abort       <= 1'b0;
        end else begin
            r_avm_read    <= w_read_nxt;
            r_avm_address <= ADDR;
            case (r_state)
                ST_ISSUE: begin
                    r_lat_cnt <= LAT_LOAD;
                    r_ivl_cnt <= IVL_W'(1);
                    r_abort   <= !enable;
                end
                ST_WAIT: begin
                    r_lat_cnt <= r_lat_cnt - 1'b1;
                    r_ivl_cnt <= r_ivl_cnt + 1'b1;
                    r_abort   <= w_abort_now;
                end
                ST_EVAL, ST_GAP: begin
                    r_lat_cnt <= '0;
                    r_ivl_cnt <= r_ivl_cnt + 1'b1;
                    r_abort   <= 1'b0;
                end
                default: begin
                    r_lat_cnt <= '0;
                    r_ivl_cnt <= '0;
                    r_abort   <= 1'b0;
                end
            endcase
        end
    end

    // Read data is looked at only on an accepted data cycle; other beats are don't-care.
    always_ff @(posedge clk) begin
        if (w_take_sample) r_sample <= ~avm_readdata[DRDY_BIT];
    end

    rh_temp_level_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filter (
        .i_clk          (clk),
        .i_rst_n        (reset_n),
        .i_sample_valid (w_sample_valid),
        .i_sample       (r_sample),
        .o_drdy_level   (drdy_level),
        .o_ready_pulse  (ready_pulse),
        .o_ready_count  (ready_count)
    );

    assign avm_read    = r_avm_read;
    assign avm_address = r_avm_address;

endmodule
